// File: rtl/rv32i_types.sv
// Shared RV32I memory-op types and LSQ entry layout.
// Entry fields are sized by LSQ_XLEN/LSQ_TAG_W; the queue's WIDTH/TAG_W default to them.
package rv32i_types;

    localparam int LSQ_XLEN  = 32;
    localparam int LSQ_TAG_W = 4;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        LSQ_IDLE,
        LSQ_LOAD_WAIT,
        LSQ_STORE_WAIT,
        LSQ_DRAIN
    } lsq_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_store;
        logic [2:0]           funct3;
        logic [LSQ_TAG_W-1:0] tag;
        logic [LSQ_XLEN-1:0]  base;
        logic                 base_rdy;
        logic [LSQ_TAG_W-1:0] base_tag;
        logic [LSQ_XLEN-1:0]  data;
        logic                 data_rdy;
        logic [LSQ_TAG_W-1:0] data_tag;
        logic [LSQ_XLEN-1:0]  imm;
    } lsq_entry_t;

    // Access size: 0 = byte, 1 = half, otherwise word.
    function automatic logic [1:0] mem_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

endpackage

// File: rtl/lsq_mem_align.sv
// Byte-lane steering for the data-memory port: enables, store shift,
// load lane select with sign/zero extension.
module lsq_mem_align
    import rv32i_types::*;
#(
    parameter int WIDTH = LSQ_XLEN
) (
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_addr_lo,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH-1:0]   i_rdata,
    output logic [WIDTH/8-1:0] o_byte_en,
    output logic [WIDTH-1:0]   o_wdata,
    output logic [WIDTH-1:0]   o_ld_data
);

    localparam int BE_W = WIDTH / 8;

    logic             w_is_byte;
    logic             w_is_half;
    logic             w_sext;
    logic [1:0]       w_off;
    logic [WIDTH-1:0] w_lane;

    always_comb begin
        w_is_byte = (mem_size(i_funct3) == 2'b00);
        w_is_half = (mem_size(i_funct3) == 2'b01);
        w_sext    = ~i_funct3[2];
        w_off     = 2'b00;
        o_byte_en = '1;
        unique case (1'b1)
            w_is_byte: begin
                w_off     = i_addr_lo;
                o_byte_en = BE_W'(1) << i_addr_lo;
            end
            w_is_half: begin
                w_off     = {i_addr_lo[1], 1'b0};
                o_byte_en = BE_W'(3) << {i_addr_lo[1], 1'b0};
            end
            default: begin
                w_off     = 2'b00;
                o_byte_en = '1;
            end
        endcase
        o_wdata   = i_wdata << {w_off, 3'b000};
        w_lane    = i_rdata >> {w_off, 3'b000};
        o_ld_data = i_rdata;
        unique case (1'b1)
            w_is_byte: o_ld_data = {{(WIDTH-8){w_lane[7] & w_sext}}, w_lane[7:0]};
            w_is_half: o_ld_data = {{(WIDTH-16){w_lane[15] & w_sext}}, w_lane[15:0]};
            default:   o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue issuing one memory transaction at a time from the head.
// Optional perf counters are built when LSQ_PERF_CNT_EN is defined.
module load_store_queue
    import rv32i_types::*;
#(
    parameter int LSQ_SIZE = 5,
    parameter int WIDTH    = LSQ_XLEN,
    parameter int TAG_W    = LSQ_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               enq_valid,
    input  logic               enq_is_store,
    input  logic [2:0]         enq_funct3,
    input  logic [TAG_W-1:0]   enq_tag,
    input  logic [WIDTH-1:0]   enq_base,
    input  logic [WIDTH-1:0]   enq_data,
    input  logic [WIDTH-1:0]   enq_imm,
    input  logic               enq_base_rdy,
    input  logic               enq_data_rdy,
    input  logic [TAG_W-1:0]   enq_base_tag,
    input  logic [TAG_W-1:0]   enq_data_tag,
    output logic               full,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [WIDTH-1:0]   cdb_data,
    input  logic               commit_store_valid,
    input  logic [TAG_W-1:0]   commit_tag,
    input  logic               mem_resp,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [WIDTH/8-1:0] mem_byte_enable,
    output logic [WIDTH-1:0]   mem_address,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               ld_valid,
    output logic [TAG_W-1:0]   ld_tag,
    output logic [WIDTH-1:0]   ld_data,
    output logic               st_done,
    output logic [TAG_W-1:0]   st_tag
`ifdef LSQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_loads,
    output logic [31:0]        perf_stores,
    output logic [31:0]        perf_wait_cycles
`endif
);

    localparam int PTR_W = (LSQ_SIZE > 1) ? $clog2(LSQ_SIZE) : 1;
    localparam int CNT_W = $clog2(LSQ_SIZE + 1);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(LSQ_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LSQ_SIZE);

    lsq_entry_t       r_q [LSQ_SIZE];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    lsq_state_t       r_state;

    lsq_entry_t         w_new;
    logic [WIDTH-1:0]   w_addr;
    logic [WIDTH/8-1:0] w_be;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH-1:0]   w_ld_ext;
    logic               w_enq;
    logic               w_deq;
    logic               w_busy;
    logic               w_ld_go;
    logic               w_st_go;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (r_count == CNT_MAX);
    assign w_addr  = r_q[r_head].base + r_q[r_head].imm;
    assign w_busy  = (r_state == LSQ_LOAD_WAIT) || (r_state == LSQ_STORE_WAIT);
    assign w_enq   = enq_valid && !full && !flush;
    assign w_deq   = w_busy && mem_resp && !flush;

    assign w_ld_go = (r_state == LSQ_IDLE) && !flush
                  && r_q[r_head].valid && !r_q[r_head].is_store
                  && r_q[r_head].base_rdy;

    assign w_st_go = (r_state == LSQ_IDLE) && !flush
                  && r_q[r_head].valid && r_q[r_head].is_store
                  && r_q[r_head].base_rdy && r_q[r_head].data_rdy
                  && commit_store_valid
                  && (commit_tag == r_q[r_head].tag);

    lsq_mem_align #(
        .WIDTH(WIDTH)
    ) u_align (
        .i_funct3  (r_q[r_head].funct3),
        .i_addr_lo (w_addr[1:0]),
        .i_wdata   (r_q[r_head].data),
        .i_rdata   (mem_rdata),
        .o_byte_en (w_be),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_ext)
    );

    // A broadcast in the dispatch cycle must land in the new entry too.
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.is_store = enq_is_store;
        w_new.funct3   = enq_funct3;
        w_new.tag      = enq_tag;
        w_new.imm      = enq_imm;
        w_new.base_tag = enq_base_tag;
        w_new.data_tag = enq_data_tag;
        w_new.base     = enq_base;
        w_new.base_rdy = enq_base_rdy;
        w_new.data     = enq_data;
        w_new.data_rdy = enq_data_rdy;
        if (!enq_base_rdy && cdb_valid && cdb_tag == enq_base_tag) begin
            w_new.base     = cdb_data;
            w_new.base_rdy = 1'b1;
        end
        if (!enq_data_rdy && cdb_valid && cdb_tag == enq_data_tag) begin
            w_new.data     = cdb_data;
            w_new.data_rdy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                r_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                if (r_q[i].valid && cdb_valid) begin
                    if (!r_q[i].base_rdy && r_q[i].base_tag == cdb_tag) begin
                        r_q[i].base     <= cdb_data;
                        r_q[i].base_rdy <= 1'b1;
                    end
                    if (!r_q[i].data_rdy && r_q[i].data_tag == cdb_tag) begin
                        r_q[i].data     <= cdb_data;
                        r_q[i].data_rdy <= 1'b1;
                    end
                end
            end
            if (w_deq) begin
                r_q[r_head].valid <= 1'b0;
            end
            if (w_enq) begin
                r_q[r_tail] <= w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_deq) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= LSQ_IDLE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            ld_valid        <= 1'b0;
            ld_tag          <= '0;
            ld_data         <= '0;
            st_done         <= 1'b0;
            st_tag          <= '0;
        end else begin
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            unique case (r_state)
                LSQ_IDLE: begin
                    if (w_ld_go) begin
                        r_state         <= LSQ_LOAD_WAIT;
                        mem_read        <= 1'b1;
                        mem_address     <= {w_addr[WIDTH-1:2], 2'b00};
                        mem_byte_enable <= w_be;
                    end else if (w_st_go) begin
                        r_state         <= LSQ_STORE_WAIT;
                        mem_write       <= 1'b1;
                        mem_address     <= {w_addr[WIDTH-1:2], 2'b00};
                        mem_byte_enable <= w_be;
                        mem_wdata       <= w_wdata;
                    end
                end
                LSQ_LOAD_WAIT, LSQ_STORE_WAIT: begin
                    if (mem_resp) begin
                        r_state   <= LSQ_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        // A flush in the response cycle retires the access silently.
                        if (!flush && r_state == LSQ_LOAD_WAIT) begin
                            ld_valid <= 1'b1;
                            ld_tag   <= r_q[r_head].tag;
                            ld_data  <= w_ld_ext;
                        end
                        if (!flush && r_state == LSQ_STORE_WAIT) begin
                            st_done <= 1'b1;
                            st_tag  <= r_q[r_head].tag;
                        end
                    end else if (flush) begin
                        r_state <= LSQ_DRAIN;
                    end
                end
                LSQ_DRAIN: begin
                    if (mem_resp) begin
                        r_state   <= LSQ_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: r_state <= LSQ_IDLE;
            endcase
        end
    end

`ifdef LSQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads       <= '0;
            perf_stores      <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (ld_valid) begin
                perf_loads <= sat_inc(perf_loads);
            end
            if (st_done) begin
                perf_stores <= sat_inc(perf_stores);
            end
            if ((mem_read || mem_write) && !mem_resp) begin
                perf_wait_cycles <= sat_inc(perf_wait_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Self-checking bench for load_store_queue: vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_load_store_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic        enq_is_store;
    logic [2:0]  enq_funct3;
    logic [3:0]  enq_tag;
    logic [31:0] enq_base;
    logic [31:0] enq_data;
    logic [31:0] enq_imm;
    logic        enq_base_rdy;
    logic        enq_data_rdy;
    logic [3:0]  enq_base_tag;
    logic [3:0]  enq_data_tag;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        commit_store_valid;
    logic [3:0]  commit_tag;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        ld_valid;
    logic [3:0]  ld_tag;
    logic [31:0] ld_data;
    logic        st_done;
    logic [3:0]  st_tag;
`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_wait_cycles;
`endif

    int checks = 0;
    int errors = 0;

    load_store_queue dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .enq_valid          (enq_valid),
        .enq_is_store       (enq_is_store),
        .enq_funct3         (enq_funct3),
        .enq_tag            (enq_tag),
        .enq_base           (enq_base),
        .enq_data           (enq_data),
        .enq_imm            (enq_imm),
        .enq_base_rdy       (enq_base_rdy),
        .enq_data_rdy       (enq_data_rdy),
        .enq_base_tag       (enq_base_tag),
        .enq_data_tag       (enq_data_tag),
        .full               (full),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_data           (cdb_data),
        .commit_store_valid (commit_store_valid),
        .commit_tag         (commit_tag),
        .mem_resp           (mem_resp),
        .mem_rdata          (mem_rdata),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_byte_enable    (mem_byte_enable),
        .mem_address        (mem_address),
        .mem_wdata          (mem_wdata),
        .ld_valid           (ld_valid),
        .ld_tag             (ld_tag),
        .ld_data            (ld_data),
        .st_done            (st_done),
        .st_tag             (st_tag)
`ifdef LSQ_PERF_CNT_EN
        ,
        .perf_loads         (perf_loads),
        .perf_stores        (perf_stores),
        .perf_wait_cycles   (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Spec-level lane arithmetic for the reference model.
    function automatic int unsigned m_off(input logic [2:0] f3,
                                          input logic [31:0] ea);
        if (f3[1:0] == 2'd0) return ea % 4;
        if (f3[1:0] == 2'd1) return ((ea % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input logic [31:0] ea);
        if (f3[1:0] == 2'd0) return 4'(1 << m_off(f3, ea));
        if (f3[1:0] == 2'd1) return 4'(3 << m_off(f3, ea));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] ea,
                                            input logic [31:0] d);
        return d << (8 * m_off(f3, ea));
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                         input logic [31:0] ea,
                                         input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * m_off(f3, ea));
        if (f3[1:0] == 2'd0) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (f3[1:0] == 2'd1) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    task automatic enq(input bit st, input logic [2:0] f3,
                       input logic [3:0] tag, input logic [31:0] base,
                       input logic [31:0] data, input logic [31:0] imm,
                       input bit brdy, input logic [3:0] btag);
        enq_valid    = 1'b1;
        enq_is_store = st;
        enq_funct3   = f3;
        enq_tag      = tag;
        enq_base     = base;
        enq_data     = data;
        enq_imm      = imm;
        enq_base_rdy = brdy;
        enq_base_tag = btag;
        enq_data_rdy = 1'b1;
        enq_data_tag = 4'd0;
        @(negedge clk);
        enq_valid    = 1'b0;
        enq_base_rdy = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_read || mem_write) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic count_req(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) seen++;
        end
    endtask

    task automatic respond(input string nm, input bit st,
                           input logic [3:0] tag, input logic [31:0] rd,
                           input logic [31:0] exp_ld);
        mem_resp  = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_resp = 1'b0;
        chk({nm, "_req_drop"}, {31'd0, mem_read | mem_write}, 32'd0);
        if (st) begin
            chk({nm, "_st_done"}, {31'd0, st_done}, 32'd1);
            chk({nm, "_st_tag"}, {28'd0, st_tag}, {28'd0, tag});
        end else begin
            chk({nm, "_ld_valid"}, {31'd0, ld_valid}, 32'd1);
            chk({nm, "_ld_tag"}, {28'd0, ld_tag}, {28'd0, tag});
            chk({nm, "_ld_data"}, ld_data, exp_ld);
        end
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
        logic [31:0] eld;
    } vec_t;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [3:0]  tag;
        logic [31:0] base;
        logic [31:0] data;
        logic [31:0] imm;
    } op_t;

    vec_t vt [11];
    op_t  mq [$];
    localparam int NRAND = 40;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          seen;
        logic [3:0]  tag;
        logic [31:0] ea;

        vt[0]  = '{0, 3'b000, 32'h100, 32'h3, 32'h0, 32'h80FF_0000,
                   32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80};
        vt[1]  = '{1, 3'b001, 32'h200, 32'h2, 32'h1234_ABCD, 32'h0,
                   32'h200, 4'b1100, 32'hABCD_0000, 32'h0};
        vt[2]  = '{0, 3'b100, 32'h10, 32'h1, 32'h0, 32'h1234_8056,
                   32'h10, 4'b0010, 32'h0, 32'h0000_0080};
        vt[3]  = '{0, 3'b001, 32'h300, 32'hFFFF_FFFE, 32'h0, 32'h9ABC_0000,
                   32'h2FC, 4'b1100, 32'h0, 32'hFFFF_9ABC};
        vt[4]  = '{0, 3'b101, 32'h400, 32'h0, 32'h0, 32'h0000_F00D,
                   32'h400, 4'b0011, 32'h0, 32'h0000_F00D};
        vt[5]  = '{0, 3'b010, 32'h500, 32'h4, 32'h0, 32'hDEAD_BEEF,
                   32'h504, 4'b1111, 32'h0, 32'hDEAD_BEEF};
        vt[6]  = '{1, 3'b000, 32'h600, 32'h5, 32'h1122_33A5, 32'h0,
                   32'h604, 4'b0010, 32'h2233_A500, 32'h0};
        vt[7]  = '{1, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'hCAFE_F00D, 32'h0,
                   32'h4, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vt[8]  = '{0, 3'b010, 32'h700, 32'h3, 32'h0, 32'h0102_0304,
                   32'h700, 4'b1111, 32'h0, 32'h0102_0304};
        vt[9]  = '{0, 3'b001, 32'h800, 32'h1, 32'h0, 32'h1234_8001,
                   32'h800, 4'b0011, 32'h0, 32'hFFFF_8001};
        vt[10] = '{0, 3'b000, 32'h20, 32'h0, 32'h0, 32'h0000_007F,
                   32'h20, 4'b0001, 32'h0, 32'h0000_007F};

        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_is_store = 1'b0;
        enq_funct3 = 3'd0; enq_tag = 4'd0; enq_base = '0; enq_data = '0;
        enq_imm = '0; enq_base_rdy = 1'b1; enq_data_rdy = 1'b1;
        enq_base_tag = 4'd0; enq_data_tag = 4'd0; cdb_valid = 1'b0;
        cdb_tag = 4'd0; cdb_data = '0; commit_store_valid = 1'b0;
        commit_tag = 4'd0; mem_resp = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_req", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_pulses", {30'd0, ld_valid, st_done}, 32'd0);
        chk("rst_addr", mem_address, 32'd0);

        // Vector table: one transaction per record.
        for (int i = 0; i < 11; i++) begin
            tag = 4'(i + 1);
            enq(vt[i].st, vt[i].f3, tag, vt[i].base, vt[i].sdata,
                vt[i].imm, 1'b1, 4'd0);
            if (vt[i].st) begin
                commit_store_valid = 1'b1;
                commit_tag = tag;
            end
            wait_req(ok);
            commit_store_valid = 1'b0;
            chk($sformatf("v%0d_issue", i), {31'd0, ok}, 32'd1);
            if (ok) begin
                chk($sformatf("v%0d_dir", i), {30'd0, mem_write, mem_read},
                    vt[i].st ? 32'd2 : 32'd1);
                chk($sformatf("v%0d_addr", i), mem_address, vt[i].eaddr);
                chk($sformatf("v%0d_be", i), {28'd0, mem_byte_enable},
                    {28'd0, vt[i].ebe});
                if (vt[i].st)
                    chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].ewdata);
                repeat (2) @(negedge clk);
                chk($sformatf("v%0d_hold", i), mem_address, vt[i].eaddr);
                respond($sformatf("v%0d", i), vt[i].st, tag, vt[i].rdata,
                        vt[i].eld);
            end
        end

        // Store without commit must never write.
        enq(1'b1, 3'b010, 4'd12, 32'h40, 32'h55, 32'h0, 1'b1, 4'd0);
        count_req(8, seen);
        chk("nocommit_write", seen, 0);
        commit_store_valid = 1'b1; commit_tag = 4'd12;
        wait_req(ok);
        commit_store_valid = 1'b0;
        chk("commit_issue", {31'd0, ok}, 32'd1);
        if (ok) respond("commit", 1'b1, 4'd12, 32'h0, 32'h0);

        // Base resolved later by the broadcast bus.
        enq(1'b0, 3'b010, 4'd4, 32'h0, 32'h0, 32'h8, 1'b0, 4'd5);
        count_req(3, seen);
        chk("cdb_wait", seen, 0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h40;
        @(negedge clk);
        cdb_valid = 1'b0;
        wait_req(ok);
        chk("cdb_addr", ok ? mem_address : 32'hDEAD_0000, 32'h48);
        if (ok) respond("cdb", 1'b0, 4'd4, 32'h7777_0001, 32'h7777_0001);

        // Broadcast in the enqueue cycle.
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h80;
        enq(1'b0, 3'b010, 4'd8, 32'h0, 32'h0, 32'h0, 1'b0, 4'd6);
        cdb_valid = 1'b0;
        wait_req(ok);
        chk("cdb_enq_addr", ok ? mem_address : 32'hDEAD_0000, 32'h80);
        if (ok) respond("cdb_enq", 1'b0, 4'd8, 32'h0000_0042, 32'h42);

        // Fill with uncommitted stores, overflow, then drain in order.
        for (int k = 1; k <= 5; k++)
            enq(1'b1, 3'b010, 4'(k), 32'h1000 + 32'(k * 4), 32'(k), 32'h0,
                1'b1, 4'd0);
        chk("full_set", {31'd0, full}, 32'd1);
        enq(1'b0, 3'b010, 4'd9, 32'h9000, 32'h0, 32'h0, 1'b1, 4'd0);
        chk("full_hold", {31'd0, full}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            commit_store_valid = 1'b1; commit_tag = 4'(k);
            wait_req(ok);
            commit_store_valid = 1'b0;
            chk($sformatf("fill%0d_addr", k), ok ? mem_address : 32'hDEAD_0000,
                32'h1000 + 32'(k * 4));
            if (!ok) break;
            respond($sformatf("fill%0d", k), 1'b1, 4'(k), 32'h0, 32'h0);
            if (k == 1) begin
                chk("full_clear", {31'd0, full}, 32'd0);
                enq(1'b1, 3'b010, 4'd6, 32'h1018, 32'h6, 32'h0, 1'b1, 4'd0);
            end
        end
        count_req(5, seen);
        chk("fill_no_ghost", seen, 0);

        // Flush with a load outstanding: drain, no pulse, then new load.
        enq(1'b0, 3'b010, 4'd3, 32'h500, 32'h0, 32'h0, 1'b1, 4'd0);
        wait_req(ok);
        chk("flush_issue", {31'd0, ok}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_full", {31'd0, full}, 32'd0);
        chk("drain_hold", {31'd0, mem_read}, 32'd1);
        enq(1'b0, 3'b010, 4'd7, 32'h900, 32'h0, 32'h0, 1'b1, 4'd0);
        @(negedge clk);
        chk("drain_addr", mem_read ? mem_address : 32'hDEAD_0000, 32'h500);
        mem_resp = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("drain_no_pulse", {30'd0, ld_valid, mem_read}, 32'd0);
        wait_req(ok);
        chk("post_drain_addr", ok ? mem_address : 32'hDEAD_0000, 32'h900);
        if (ok) respond("post_drain", 1'b0, 4'd7, 32'h1122_3344, 32'h1122_3344);
        count_req(5, seen);
        chk("flush_no_ghost", seen, 0);

        // Reset in the middle of a load.
        enq(1'b0, 3'b010, 4'd2, 32'h300, 32'h0, 32'h0, 1'b1, 4'd0);
        wait_req(ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rstmid_full", {31'd0, full}, 32'd0);
        chk("rstmid_ld", ld_data, 32'd0);
        chk("rstmid_addr", mem_address, 32'd0);
        count_req(5, seen);
        chk("rstmid_no_ghost", seen, 0);

        // Randomized traffic against the queue model.
        fork
            begin : producer
                for (int i = 0; i < NRAND; i++) begin
                    op_t op;
                    int  w;
                    logic [2:0] lf [5];
                    lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010;
                    lf[3] = 3'b100; lf[4] = 3'b101;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    w = 0;
                    while (full && w < 500) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 500) begin
                        chk("rand_full_stuck", 32'd1, 32'd0);
                        break;
                    end
                    op.st   = ($urandom_range(0, 2) == 0);
                    op.f3   = op.st ? 3'($urandom_range(0, 2))
                                    : lf[$urandom_range(0, 4)];
                    op.tag  = 4'(i);
                    op.base = $urandom;
                    op.data = $urandom;
                    op.imm  = 32'($urandom_range(0, 64)) - 32'd32;
                    mq.push_back(op);
                    enq(op.st, op.f3, op.tag, op.base, op.data, op.imm,
                        1'b1, 4'd0);
                end
            end
            begin : bus
                int   done;
                bit   ghost;
                op_t  h;
                logic [31:0] rd;
                done  = 0;
                ghost = 1'b0;
                for (int cyc = 0; cyc < 6000 && done < NRAND && !ghost; cyc++) begin
                    @(negedge clk);
                    commit_store_valid = (mq.size() > 0) && mq[0].st;
                    commit_tag = (mq.size() > 0) ? mq[0].tag : 4'd0;
                    if (mem_read || mem_write) begin
                        if (mq.size() == 0) begin
                            chk("rand_ghost", 32'd1, 32'd0);
                            ghost = 1'b1;
                        end else begin
                            h  = mq[0];
                            ea = h.base + h.imm;
                            chk("rand_dir", {30'd0, mem_write, mem_read},
                                h.st ? 32'd2 : 32'd1);
                            chk("rand_addr", mem_address, ea & 32'hFFFF_FFFC);
                            chk("rand_be", {28'd0, mem_byte_enable},
                                {28'd0, m_be(h.f3, ea)});
                            if (h.st)
                                chk("rand_wdata", mem_wdata,
                                    m_wdata(h.f3, ea, h.data));
                            repeat ($urandom_range(0, 3)) @(negedge clk);
                            rd = $urandom;
                            respond("rand", h.st, h.tag, rd, m_ld(h.f3, ea, rd));
                            void'(mq.pop_front());
                            done++;
                            commit_store_valid = (mq.size() > 0) && mq[0].st;
                            commit_tag = (mq.size() > 0) ? mq[0].tag : 4'd0;
                        end
                    end
                end
                commit_store_valid = 1'b0;
                chk("rand_done", done, NRAND);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
